// File: rtl/fetch_stage.sv
// Instruction-fetch front end: issues req/ack fetches to instruction memory and
// presents pc+step / instruction pairs to ID, honouring freeze and branch redirect.
module fetch_stage #(
    parameter int unsigned                 ADDR_WIDTH = 32,
    parameter int unsigned                 DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]       RESET_PC   = '0,
    parameter int unsigned                 PC_STEP    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  freeze,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_addr,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [DATA_WIDTH-1:0] instruction_out,
    output logic                  valid_out
);

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] pc, pc_n;
    logic [ADDR_WIDTH-1:0] hold_pc, hold_pc_n;
    logic [DATA_WIDTH-1:0] hold_instr, hold_instr_n;
    logic [ADDR_WIDTH-1:0] pc_out_n;
    logic [DATA_WIDTH-1:0] instr_n;
    logic                  valid_n;
    logic                  mem_req_n;
    logic [ADDR_WIDTH-1:0] mem_addr_n;
    logic                  ack_c;

    // An ack only counts against a live request.
    assign ack_c = mem_req & mem_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= FETCH;
            pc              <= RESET_PC;
            hold_pc         <= '0;
            hold_instr      <= '0;
            pc_out          <= '0;
            instruction_out <= '0;
            valid_out       <= 1'b0;
            mem_req         <= 1'b0;
            mem_addr        <= RESET_PC;
        end else begin
            state           <= state_n;
            pc              <= pc_n;
            hold_pc         <= hold_pc_n;
            hold_instr      <= hold_instr_n;
            pc_out          <= pc_out_n;
            instruction_out <= instr_n;
            valid_out       <= valid_n;
            mem_req         <= mem_req_n;
            mem_addr        <= mem_addr_n;
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        hold_pc_n    = hold_pc;
        hold_instr_n = hold_instr;
        pc_out_n     = pc_out;
        instr_n      = instruction_out;
        valid_n      = valid_out;
        mem_req_n    = mem_req;
        mem_addr_n   = mem_addr;

        if (branch_taken) begin
            // Redirect beats freeze and ack; an unacked request must be drained first.
            pc_n         = branch_addr;
            valid_n      = 1'b0;
            hold_pc_n    = '0;
            hold_instr_n = '0;
            if (mem_req && !mem_ack) begin
                state_n = DRAIN;
            end else begin
                state_n    = FETCH;
                mem_req_n  = 1'b1;
                mem_addr_n = branch_addr;
            end
        end else begin
            unique case (state)
                FETCH: begin
                    if (freeze) begin
                        if (ack_c) begin
                            hold_pc_n    = mem_addr + STEP;
                            hold_instr_n = mem_rdata;
                            pc_n         = pc + STEP;
                            mem_req_n    = 1'b0;
                            state_n      = HOLD;
                        end else begin
                            mem_req_n  = 1'b1;
                            mem_addr_n = pc;
                        end
                    end else if (ack_c) begin
                        pc_out_n   = mem_addr + STEP;
                        instr_n    = mem_rdata;
                        valid_n    = 1'b1;
                        pc_n       = pc + STEP;
                        mem_req_n  = 1'b1;
                        mem_addr_n = pc + STEP;
                    end else begin
                        valid_n    = 1'b0;
                        mem_req_n  = 1'b1;
                        mem_addr_n = pc;
                    end
                end
                HOLD: begin
                    if (!freeze) begin
                        pc_out_n   = hold_pc;
                        instr_n    = hold_instr;
                        valid_n    = 1'b1;
                        mem_req_n  = 1'b1;
                        mem_addr_n = pc;
                        state_n    = FETCH;
                    end
                end
                DRAIN: begin
                    // Stale response is dropped; refetch at the redirect target.
                    if (ack_c) begin
                        mem_req_n  = 1'b1;
                        mem_addr_n = pc;
                        state_n    = FETCH;
                    end
                end
                default: begin
                    state_n   = FETCH;
                    mem_req_n = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming, wait states, freeze park,
// branch drain, branch+freeze, address wrap and mid-transaction reset.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        valid_out;

    int unsigned n_checks;
    int unsigned n_errors;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .freeze         (freeze),
        .branch_taken   (branch_taken),
        .branch_addr    (branch_addr),
        .pc_out         (pc_out),
        .instruction_out(instruction_out),
        .valid_out      (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b0;
        mem_ack      = 1'b0;
        mem_rdata    = '0;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = '0;

        // Reset held for two cycles
        step();
        step();
        check("rst_req",   32'(mem_req), 32'd0);
        check("rst_pc",    pc_out, 32'd0);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_instr", instruction_out, 32'd0);

        rst = 1'b1;
        step();
        check("first_req",  32'(mem_req), 32'd1);
        check("first_addr", mem_addr, 32'd0);

        // Zero-wait stream
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_rdata = mem_addr / 4 + 100;
            step();
            check("zw_pc",    pc_out, 32'(4 * (i + 1)));
            check("zw_instr", instruction_out, 32'(100 + i));
            check("zw_valid", 32'(valid_out), 32'd1);
        end
        check("zw_addr", mem_addr, 32'd16);

        // Two wait states per request
        for (int i = 0; i < 2; i++) begin
            mem_ack = 1'b0;
            for (int w = 0; w < 2; w++) begin
                step();
                check("ws_valid0", 32'(valid_out), 32'd0);
                check("ws_addr",   mem_addr, 32'(16 + 4 * i));
                check("ws_req",    32'(mem_req), 32'd1);
            end
            mem_ack   = 1'b1;
            mem_rdata = 32'(104 + i);
            step();
            check("ws_valid1", 32'(valid_out), 32'd1);
            check("ws_pc",     pc_out, 32'(20 + 4 * i));
            check("ws_instr",  instruction_out, 32'(104 + i));
        end
        check("ws_next", mem_addr, 32'd24);

        // Branch on an acked request: target requested next cycle
        branch_taken = 1'b1;
        branch_addr  = 32'd8;
        mem_rdata    = 32'hBAD0_0018;
        step();
        branch_taken = 1'b0;
        check("br_ack_valid", 32'(valid_out), 32'd0);
        check("br_ack_addr",  mem_addr, 32'd8);
        check("br_ack_req",   32'(mem_req), 32'd1);

        // Freeze with the word at 8 parked
        freeze    = 1'b1;
        mem_rdata = 32'hE3A0_1005;
        step();
        mem_ack = 1'b0;
        check("fz_req",   32'(mem_req), 32'd0);
        check("fz_valid", 32'(valid_out), 32'd0);
        check("fz_pc",    pc_out, 32'd24);
        for (int i = 0; i < 2; i++) begin
            step();
            check("fz_hold_req", 32'(mem_req), 32'd0);
            check("fz_hold_pc",  pc_out, 32'd24);
            check("fz_hold_ins", instruction_out, 32'd105);
        end
        freeze = 1'b0;
        step();
        check("unfz_pc",    pc_out, 32'd12);
        check("unfz_instr", instruction_out, 32'hE3A0_1005);
        check("unfz_valid", 32'(valid_out), 32'd1);
        check("unfz_addr",  mem_addr, 32'd12);
        check("unfz_req",   32'(mem_req), 32'd1);

        // Advance to an outstanding request at 20
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_000C;
        step();
        mem_rdata = 32'h0000_0010;
        step();
        check("adv_pc", pc_out, 32'd20);
        mem_ack = 1'b0;
        step();
        check("pend_addr", mem_addr, 32'd20);

        // Branch while it is outstanding -> drain
        branch_taken = 1'b1;
        branch_addr  = 32'h40;
        step();
        branch_taken = 1'b0;
        check("drn_addr",  mem_addr, 32'd20);
        check("drn_req",   32'(mem_req), 32'd1);
        check("drn_valid", 32'(valid_out), 32'd0);
        step();
        check("drn_addr2", mem_addr, 32'd20);
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        step();
        check("drn_drop_valid", 32'(valid_out), 32'd0);
        check("drn_new_addr",   mem_addr, 32'h40);
        mem_rdata = 32'h0000_1234;
        step();
        check("tgt_pc",    pc_out, 32'h44);
        check("tgt_instr", instruction_out, 32'h0000_1234);
        check("tgt_valid", 32'(valid_out), 32'd1);

        // Branch and freeze together: squash
        freeze       = 1'b1;
        branch_taken = 1'b1;
        branch_addr  = 32'hFFFF_FFFC;
        step();
        freeze       = 1'b0;
        branch_taken = 1'b0;
        check("bf_valid", 32'(valid_out), 32'd0);
        check("bf_addr",  mem_addr, 32'hFFFF_FFFC);

        // Wrap at top of address space
        mem_rdata = 32'd77;
        step();
        check("wrap_pc",    pc_out, 32'd0);
        check("wrap_instr", instruction_out, 32'd77);
        check("wrap_addr",  mem_addr, 32'd0);

        // Reset mid-transaction, late ack after release is ignored
        mem_ack = 1'b0;
        step();
        rst = 1'b0;
        #1;
        check("async_req",   32'(mem_req), 32'd0);
        check("async_valid", 32'(valid_out), 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_5555;
        step();
        rst = 1'b1;
        step();
        check("late_valid", 32'(valid_out), 32'd0);
        check("late_req",   32'(mem_req), 32'd1);
        check("late_addr",  mem_addr, 32'd0);
        check("late_pc",    pc_out, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end of the ARM pipeline.
- Drives the pc + instruction pair consumed by the ID stage, i.e. the producer side of the pc_in/instruction_in interface.
- Issues requests to the instruction memory over a req/ack handshake that tolerates wait states.
- Honours hazard freeze and branch redirect from later stages.

Parameters:
ADDR_WIDTH, 32, width of pc and memory address
DATA_WIDTH, 32, instruction width
RESET_PC, 0, first fetch address after reset
PC_STEP, 4, byte increment between sequential fetches

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
mem_req  output  1  fetch request to instruction memory
mem_addr  output  ADDR_WIDTH  fetch address, stable while mem_req=1 and no ack
mem_ack  input  1  memory returns mem_rdata this cycle
mem_rdata  input  DATA_WIDTH  instruction word, valid when mem_ack=1
freeze  input  1  hazard stall from ID; hold outputs, stop advancing
branch_taken  input  1  redirect request from EXE
branch_addr  input  ADDR_WIDTH  redirect target
pc_out  output  ADDR_WIDTH  fetched address + PC_STEP (to ID pc_in)
instruction_out  output  DATA_WIDTH  fetched instruction (to ID instruction_in)
valid_out  output  1  pc_out/instruction_out hold a real instruction

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC; state=FETCH; mem_req=0.
  - pc_out=0, instruction_out=0, valid_out=0.
  - Hold register cleared.
- First request: mem_req rises on the first clk edge after rst deasserts.
- States:
  - FETCH: mem_req=1, mem_addr=pc.
  - HOLD: mem_req=0, a fetched word is parked.
  - DRAIN: mem_req=1, mem_addr=old pc, waiting to discard the in-flight response.
- Handshake:
  - A request completes on the cycle mem_ack=1 while mem_req=1.
  - mem_addr must not change between request assert and ack.
  - Zero-wait memory (ack in the same cycle as req) is legal.
  - mem_ack while mem_req=0 is ignored.
- FETCH, ack, freeze=0, branch_taken=0:
  - Next edge: pc_out=pc+PC_STEP, instruction_out=mem_rdata, valid_out=1.
  - pc advances by PC_STEP; the next request issues the following cycle.
  - Sustained throughput is 1 instruction/cycle with zero-wait memory.
- FETCH, no ack, freeze=0: valid_out=0 next edge (bubble); pc_out/instruction_out hold their values.
- Freeze=1:
  - pc_out, instruction_out and valid_out all hold.
  - If ack arrives during freeze: the word and its pc+PC_STEP go into the hold register, pc advances, state→HOLD, mem_req drops next cycle.
- HOLD, freeze=0: the hold register moves to the outputs with valid_out=1; state→FETCH.
- Branch (branch_taken=1) has priority over freeze and ack:
  - pc=branch_addr; valid_out=0 next edge; hold register discarded.
  - If the current request is acked this cycle, or no request is outstanding: state→FETCH, so the target is requested next cycle.
  - If a request is outstanding and not acked: state→DRAIN. Once DRAIN's ack arrives, the word is dropped and state→FETCH at the target.
  - A branch during DRAIN updates the target again and stays in DRAIN.
- Freeze and branch together: the branch wins; outputs are squashed to valid_out=0.
- pc arithmetic is modulo 2^ADDR_WIDTH; wrap at the top of the address space is silent.
- Reset asserted mid-transaction aborts immediately; any late mem_ack after reset release while mem_req=0 is ignored.

Test Plan:
- Reset: hold rst=0 for 2 cycles → mem_req=0, pc_out=0, valid_out=0. Release → mem_req=1, mem_addr=0 on the next cycle.
- Zero-wait stream: mem_ack tied 1, mem_rdata=addr/4+100 → pc_out 4,8,12,16 on consecutive cycles, instruction_out 100..103, valid_out=1 throughout.
- Wait states: ack 2 cycles after each req → mem_addr held constant until ack; valid_out pattern 0,0,1 repeating; pc_out increments by 4 per valid.
- Freeze with parked word: freeze=1 for 3 cycles while ack(addr 8, data 0xE3A01005) lands → outputs frozen, mem_req=0 after park. Freeze drops → pc_out=12, instruction_out=0xE3A01005, valid_out=1, next mem_addr=12.
- Branch during outstanding fetch: req addr 20 pending, branch_taken with branch_addr=0x40, ack 2 cycles later → DRAIN keeps mem_addr=20; that word never appears with valid_out=1; next mem_addr=0x40; then pc_out=0x44.
- Edge cases:
  - branch_taken and freeze together → valid_out=0 next cycle.
  - pc=0xFFFFFFFC fetched → next mem_addr=0.
